pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Upstream neighbour of the IF/ID register: owns the fetch PC, issues requests on a
//  req/gnt/rvalid instruction bus and buffers returned words in a small in-order FIFO.
//  Drives inst/addr (NOP when nothing valid) into IF/ID. Handles jump flush from EX and
//  the pipeline hold bus. Responses for squashed requests are discarded by count.
// PARAMETERS
//  RESET_ADDR   32'h0000_0000  first fetch address after reset (word aligned)
//  FIFO_DEPTH   2              instruction buffer entries (>=1); also max outstanding+buffered
//  INST_NOP     32'h0000_0013  word driven on inst_o when no valid instruction
// PORTS
//  clk_i          in   1   clock
//  rst_n_i        in   1   asynchronous active-low reset
//  hold_flag_i    in   3   hold bus: 0 NONE, 1 HOLD_PC, 2 HOLD_IF, 3 HOLD_ID
//  jump_flag_i    in   1   redirect fetch this cycle
//  jump_addr_i    in   32  redirect target
//  ibus_req_o     out  1   fetch request valid
//  ibus_addr_o    out  32  fetch address (word aligned)
//  ibus_gnt_i     in   1   request accepted this cycle
//  ibus_rvalid_i  in   1   read data valid (in order, >=1 cycle after gnt, no backpressure)
//  ibus_rdata_i   in   32  read data
//  inst_o         out  32  instruction to IF/ID
//  inst_addr_o    out  32  address of inst_o
//  inst_valid_o   out  1   inst_o is a real fetched instruction
// BEHAVIOUR
//  Reset (async, rst_n_i=0): req_pc=RESET_ADDR, FIFO empty, outstanding=0, discard=0;
//   outputs: ibus_req_o=0, ibus_addr_o=RESET_ADDR, inst_o=INST_NOP, inst_addr_o=RESET_ADDR,
//   inst_valid_o=0. Req may assert in first cycle after release.
//  Credit: ibus_req_o = (outstanding + fifo_count < FIFO_DEPTH) & !jump_flag_i.
//   FIFO can therefore never overflow; rvalid is always accepted.
//  Request: ibus_addr_o=req_pc. On req&gnt: req_pc+=4 (wraps 0xFFFF_FFFC->0), outstanding++.
//   While req&!gnt, req and addr held stable (credit cannot drop: only pops free space).
//  Response: rvalid with discard==0 pushes {resp_pc, rdata}, resp_pc+=4, outstanding--.
//   rvalid with discard>0: data dropped, discard--, outstanding--.
//  Output: inst_o/inst_addr_o/inst_valid_o driven from FIFO head (registered storage, no
//   bus->output comb path); empty -> INST_NOP, addr of last head (or RESET_ADDR), valid=0.
//  Pop: head popped at clock edge when !empty & hold_flag_i==0 & !jump_flag_i.
//   hold_flag_i>=1: no pop, head held; requests continue while credit remains.
//  Simultaneous push+pop on same edge allowed (count unchanged); push into empty FIFO
//   visible on outputs the following cycle.
//  Jump (priority over hold and push/pop): on edge with jump_flag_i=1:
//   FIFO cleared; req_pc=resp_pc={jump_addr_i[31:2],2'b00}; discard = outstanding after this
//   cycle's rvalid accounting (any rvalid this cycle is itself dropped). ibus_req_o is 0 in
//   the jump cycle so no stale request is granted. inst_valid_o=0 next cycle.
//  Latency (zero-wait bus: gnt same cycle, rvalid next): reset release at T0 -> req T0,
//   rvalid T1, inst_valid_o T2. Jump at N -> target req N+1, valid at N+3.
//  Back-to-back jumps: each re-computes discard; outstanding never exceeds FIFO_DEPTH.
//  Invariant (assert): outstanding+fifo_count<=FIFO_DEPTH; discard<=outstanding;
//   no rvalid when outstanding==0.
// TESTING
//  1 Reset, zero-wait bus, data=addr^0xA5A5_0000 -> inst_addr_o 0,4,8,... one per cycle from T2,
//    inst_valid_o=1 continuously, inst_o matches.
//  2 hold_flag_i=2 for 5 cycles mid-stream at head addr 0x10 -> inst_o/addr frozen at 0x10,
//    ibus_req_o drops once 2 words buffered; release -> 0x14,0x18 with no gap or duplicate.
//  3 gnt held low 4 cycles with req up -> ibus_addr_o stable, no push; gnt -> resumes in order.
//  4 rvalid latency 3, jump to 0x0000_0103 with 2 outstanding -> both late responses dropped,
//    next valid inst_addr_o=0x100, inst_valid_o low in between, never shows stale addr.
//  5 Jump to 0xFFFF_FFF8 -> addresses 0xFFFF_FFF8,0xFFFF_FFFC,0x0000_0000 in sequence.
//  6 rst_n_i asserted with outstanding requests and full FIFO -> outputs reset immediately
//    (async); after release fetch restarts at RESET_ADDR, pre-reset rvalids not expected.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch PC owner: issues word fetches on req/gnt/rvalid and buffers responses in order for IF/ID.
// Latency gnt->inst_valid_o is rvalid delay + 1; requests gated by credit, rvalid never stalled, hold stalls pops.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] INST_NOP   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  hold_flag_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] word;
    } fetch_ent_t;

    logic [31:0]   req_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   last_addr;
    logic [31:0]   jump_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outs_after_rsp;
    logic [CW:0]   occupancy;
    logic          credit;
    logic          gnt_fire;
    logic          rsp_drop;
    logic          push_vld;
    logic          pop_vld;
    logic          fifo_empty;
    logic          unused_fifo_full;
    logic          unused_jump_lsb;
    fetch_ent_t    push_dat;
    fetch_ent_t    head_dat;

    assign jump_pc         = {jump_addr_i[31:2], 2'b00};
    assign unused_jump_lsb = ^jump_addr_i[1:0];

    // Every buffered word and every in-flight request holds one FIFO slot,
    // so a returning rvalid always has somewhere to land.
    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit    = occupancy < DEPTH_C;

    assign ibus_req_o  = rst_n_i & credit & ~jump_flag_i;
    assign ibus_addr_o = req_pc;
    assign gnt_fire    = ibus_req_o & ibus_gnt_i;

    assign rsp_drop       = (discard != '0);
    assign push_vld       = ibus_rvalid_i & ~rsp_drop & ~jump_flag_i;
    assign pop_vld        = ~fifo_empty & (hold_flag_i == 3'd0) & ~jump_flag_i;
    assign push_dat       = '{addr: resp_pc, word: ibus_rdata_i};
    assign outs_after_rsp = outstanding - CW'(ibus_rvalid_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_pc      <= RESET_ADDR;
            resp_pc     <= RESET_ADDR;
            last_addr   <= RESET_ADDR;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outs_after_rsp + CW'(gnt_fire);
            if (!fifo_empty) begin
                last_addr <= head_dat.addr;
            end
            // Everything still in flight after this cycle's response belongs to the old path.
            if (jump_flag_i) begin
                req_pc  <= jump_pc;
                resp_pc <= jump_pc;
                discard <= outs_after_rsp;
            end else begin
                if (gnt_fire) begin
                    req_pc <= req_pc + 32'd4;
                end
                if (push_vld) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (ibus_rvalid_i && rsp_drop) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    pc_fetch_fifo #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .flush    (jump_flag_i),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (unused_fifo_full)
    );

    assign inst_valid_o = ~fifo_empty;
    assign inst_o       = fifo_empty ? INST_NOP : head_dat.word;
    assign inst_addr_o  = fifo_empty ? last_addr : head_dat.addr;

    a_credit: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        occupancy <= DEPTH_C);
    a_discard: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        discard <= outstanding);
    a_rvalid: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ibus_rvalid_i |-> (outstanding != '0));

endmodule

// Generic in-order FIFO with synchronous flush; head is read straight from registered storage.
// Latency: a push is visible at the head the cycle after it; push into a full FIFO is ignored unless it pops too.
module pc_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop_vld & ~empty;
    assign do_push  = push_vld & (~full | do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a scripted req/gnt/rvalid memory returns addr^KEY after a set latency.
module tb_pc_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [2:0]  hold_flag_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    always #5 clk_i = ~clk_i;

    pc_fetch_unit #(
        .RESET_ADDR (32'h0000_0000),
        .FIFO_DEPTH (3),
        .INST_NOP   (NOP)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .hold_flag_i   (hold_flag_i),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o)
    );

    int          checks = 0;
    int          errors = 0;
    int          now = 0;
    int          lat = 1;
    logic        gnt_en = 1'b1;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] a);
        chk({tag, "_vld"}, 32'(inst_valid_o), 32'd1);
        chk({tag, "_addr"}, inst_addr_o, a);
        chk({tag, "_inst"}, inst_o, a ^ KEY);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_vld"}, 32'(inst_valid_o), 32'd0);
        chk({tag, "_nop"}, inst_o, NOP);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, "_req"}, 32'(ibus_req_o), 32'(r));
        if (r) chk({tag, "_baddr"}, ibus_addr_o, a);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(ibus_req_o), 32'd0);
        chk({tag, "_baddr"}, ibus_addr_o, 32'h0);
        chk({tag, "_iaddr"}, inst_addr_o, 32'h0);
        chk_empty(tag);
    endtask

    // Drive this cycle's bus response and grant, then log any accepted request.
    task automatic drive();
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = '0;
        if (pend_addr.size() != 0 && pend_due[0] <= now) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = pend_addr[0] ^ KEY;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        ibus_gnt_i = gnt_en;
        #1;
        if (ibus_req_o && ibus_gnt_i) begin
            pend_addr.push_back(ibus_addr_o);
            pend_due.push_back(now + lat);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        now++;
    endtask

    initial begin
        rst_n_i       = 1'b0;
        hold_flag_i   = 3'd0;
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'h0;
        ibus_gnt_i    = 1'b0;
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'h0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        chk_reset("reset");
        rst_n_i = 1'b1;

        // zero-wait stream from reset
        drive(); chk_req("t1_T0", 1'b1, 32'h0); chk_empty("t1_T0"); tick();
        drive(); chk_req("t1_T1", 1'b1, 32'h4); chk_empty("t1_T1"); tick();
        for (int k = 0; k < 4; k++) begin
            drive(); chk_head("t1_stream", 32'(4 * k)); tick();
        end

        // hold IF for five cycles with head 0x10
        hold_flag_i = 3'd2;
        drive(); chk_head("t2_hold0", 32'h10); chk_req("t2_T6", 1'b1, 32'h18); tick();
        for (int k = 0; k < 4; k++) begin
            drive(); chk_head("t2_hold", 32'h10); chk_req("t2_full", 1'b0, 32'h0); tick();
        end
        hold_flag_i = 3'd0;
        drive(); chk_head("t2_rel", 32'h10); chk_req("t2_rel", 1'b0, 32'h0); tick();
        drive(); chk_head("t2_next", 32'h14); chk_req("t2_resume", 1'b1, 32'h1C); tick();
        for (int k = 0; k < 3; k++) begin
            drive(); chk_head("t2_after", 32'h18 + 32'(4 * k)); tick();
        end

        // grant withheld for four cycles
        gnt_en = 1'b0;
        drive(); chk_head("t3_a", 32'h24); chk_req("t3_a", 1'b1, 32'h2C); tick();
        drive(); chk_head("t3_b", 32'h28); chk_req("t3_b", 1'b1, 32'h2C); tick();
        for (int k = 0; k < 2; k++) begin
            drive(); chk_empty("t3_starve"); chk("t3_last", inst_addr_o, 32'h28);
            chk_req("t3_stable", 1'b1, 32'h2C); tick();
        end
        gnt_en = 1'b1;
        drive(); chk_empty("t3_gnt"); chk_req("t3_gnt", 1'b1, 32'h2C); tick();
        drive(); chk_empty("t3_wait"); chk_req("t3_wait", 1'b1, 32'h30); tick();
        drive(); chk_head("t3_c", 32'h2C); tick();
        drive(); chk_head("t3_d", 32'h30); tick();

        // latency 3, jump with two requests in flight
        lat = 3;
        drive(); chk_head("t4_a", 32'h34); chk_req("t4_a", 1'b1, 32'h3C); tick();
        drive(); chk_head("t4_b", 32'h38); chk_req("t4_b", 1'b1, 32'h40); tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0103;
        drive(); chk_req("t4_jump", 1'b0, 32'h0); chk_empty("t4_jump"); tick();
        jump_flag_i = 1'b0;
        drive(); chk_req("t4_tgt", 1'b1, 32'h100); chk_empty("t4_drop1"); tick();
        drive(); chk_req("t4_tgt1", 1'b1, 32'h104); chk_empty("t4_drop2"); tick();
        drive(); chk_req("t4_tgt2", 1'b1, 32'h108); chk_empty("t4_gap"); tick();
        drive(); chk_req("t4_cred", 1'b0, 32'h0); chk_empty("t4_gap2"); tick();
        drive(); chk_head("t4_new0", 32'h100); tick();
        drive(); chk_head("t4_new1", 32'h104); tick();
        drive(); chk_head("t4_new2", 32'h108); tick();

        // fill under hold, then async reset mid-cycle
        hold_flag_i = 3'd1;
        drive(); chk_empty("t6_a"); chk_req("t6_a", 1'b1, 32'h114); tick();
        drive(); chk_empty("t6_b"); chk_req("t6_b", 1'b0, 32'h0); tick();
        drive(); chk_head("t6_c", 32'h10C); chk_req("t6_c", 1'b0, 32'h0); tick();
        drive(); chk_head("t6_d", 32'h10C); chk_req("t6_d", 1'b0, 32'h0);
        rst_n_i       = 1'b0;
        ibus_rvalid_i = 1'b0;
        hold_flag_i   = 3'd0;
        lat           = 1;
        pend_addr.delete();
        pend_due.delete();
        #1;
        chk_reset("t6_async");
        tick();
        chk_reset("t6_held");
        rst_n_i = 1'b1;
        now     = 0;

        // restart from reset, then jump near the top of the address space
        drive(); chk_req("t5_T0", 1'b1, 32'h0); chk_empty("t5_T0"); tick();
        drive(); chk_req("t5_T1", 1'b1, 32'h4); chk_empty("t5_T1"); tick();
        drive(); chk_head("t5_h0", 32'h0); tick();
        drive(); chk_head("t5_h4", 32'h4); tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'hFFFF_FFF8;
        drive(); chk_head("t5_jump", 32'h8); chk_req("t5_jump", 1'b0, 32'h0); tick();
        jump_flag_i = 1'b0;
        drive(); chk_empty("t5_e0"); chk("t5_lastaddr", inst_addr_o, 32'h8);
        chk_req("t5_r0", 1'b1, 32'hFFFF_FFF8); tick();
        drive(); chk_empty("t5_e1"); chk_req("t5_r1", 1'b1, 32'hFFFF_FFFC); tick();
        drive(); chk_head("t5_w0", 32'hFFFF_FFF8); chk_req("t5_wrap", 1'b1, 32'h0); tick();
        drive(); chk_head("t5_w1", 32'hFFFF_FFFC); tick();
        drive(); chk_head("t5_w2", 32'h0000_0000); tick();
        drive(); chk_head("t5_w3", 32'h0000_0004); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
